// File: rtl/run_ctrl_if.sv
// rtl/run_ctrl_if.sv - control/status bundle between a run controller and its host
// Purpose: groups the run request/observation inputs and the controller status
//          outputs so they travel as a single port.
// Signals:
//   start        host -> ctrl  single-cycle request to begin a run
//   halt         host -> ctrl  core end-of-program indication
//   pc           host -> ctrl  core fetch PC (stall observation)
//   core_reset   ctrl -> host  reset for the core under control
//   running      ctrl -> host  high while the core is running
//   done         ctrl -> host  sticky run-finished flag
//   timeout      ctrl -> host  sticky, run ended on cycle budget
//   stalled      ctrl -> host  sticky, run ended on PC stall
//   cycle_count  ctrl -> host  RUN cycles of the current or last run
interface run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             halt;
  logic [PC_W-1:0]  pc;
  logic             core_reset;
  logic             running;
  logic             done;
  logic             timeout;
  logic             stalled;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, halt, pc,
    input  core_reset, running, done, timeout, stalled, cycle_count
  );

  modport slave (
    input  start, halt, pc,
    output core_reset, running, done, timeout, stalled, cycle_count
  );
endinterface

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run controller: core reset sequencing, run budget and stall watchdog
// Purpose: on start, holds the core in reset for RST_CYCLES cycles, releases it,
//          counts RUN cycles and ends the run on halt, PC stall or budget
//          exhaustion. All outputs are registered.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    run_ctrl_if.slave (start/halt/pc in; core_reset/running/done/
//          timeout/stalled/cycle_count out)
// Optional feature: define RUN_CTRL_STALL_DETECT_EN to compile in PC stall
//          detection; otherwise stalled is constant 0 and pc is ignored.
module run_ctrl #(
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 200,
  parameter int STALL_LIMIT = 16,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16
) (
  input  logic      clk,
  input  logic      reset,
  run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              stalled_q, stalled_d;
  logic              core_reset_q, core_reset_d;
  logic              running_q, running_d;
  logic              stall_hit;

`ifdef RUN_CTRL_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

  logic [PC_W-1:0] pc_q;
  logic [SW-1:0]   stall_q, stall_d;
  logic            pc_same;

  // The counter only means something inside RUN; holding it at zero
  // elsewhere also gives the clear-on-entering-HOLD behaviour.
  always_comb begin
    pc_same   = (bus.pc == pc_q);
    stall_d   = '0;
    stall_hit = 1'b0;
    if (state_q == RUN) begin
      if (pc_same) begin
        stall_d   = stall_q + 1'b1;
        stall_hit = (stall_q == STALL_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      stall_q <= '0;
    end else begin
      if (state_q == HOLD || state_q == RUN) begin
        pc_q <= bus.pc;
      end
      stall_q <= stall_d;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^{bus.pc, 32'(STALL_LIMIT)};
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    stalled_d = stalled_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = HOLD;
          hold_d    = '0;
          cnt_d     = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          stalled_d = 1'b0;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        // The terminating edge is counted too, so a budget run ends at
        // exactly MAX_CYCLES and the counter can never go past it.
        cnt_d = cnt_q + 1'b1;
        if (bus.halt) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (stall_hit) begin
          state_d   = DONE;
          done_d    = 1'b1;
          stalled_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs follow the state being entered.
    core_reset_d = (state_d != RUN);
    running_d    = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      stalled_q    <= 1'b0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      stalled_q    <= stalled_d;
      core_reset_q <= core_reset_d;
      running_q    <= running_d;
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.stalled     = stalled_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - self-checking bench for run_ctrl (RST_CYCLES=2, MAX_CYCLES=10, STALL_LIMIT=4)
module tb_run_ctrl;

`ifdef RUN_CTRL_STALL_DETECT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  run_ctrl_if #(.PC_W(32), .CNT_W(16)) bus ();

  run_ctrl #(
    .RST_CYCLES (2),
    .MAX_CYCLES (10),
    .STALL_LIMIT(4),
    .PC_W       (32),
    .CNT_W      (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int halt_at;   // RUN cycle on which halt is high, 0 = never
    bit const_pc;  // 1: pc held at 0x40, 0: pc steps by 4
    bit e_to;
    bit e_st;
    int e_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    bus.pc    = 32'h0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Leaves the DUT in RUN cycle 1.
  task automatic start_run(input bit const_pc);
    bus.pc    = const_pc ? 32'h40 : 32'h100;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
  endtask

  // Cycle numbering starts at 1 for the current RUN cycle; bounded to 20.
  task automatic run_until(input int halt_at, input bit const_pc);
    for (int c = 1; c <= 20; c++) begin
      bus.halt = (c == halt_at);
      if (!const_pc) bus.pc = 32'h100 + 32'(4 * c);
      tick;
      if (bus.done) break;
    end
    bus.halt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{halt_at: 5,  const_pc: 1'b0, e_to: 1'b0, e_st: 1'b0, e_cnt: 5};
    vecs[1] = '{halt_at: 0,  const_pc: 1'b0, e_to: 1'b1, e_st: 1'b0, e_cnt: 10};
    vecs[2] = '{halt_at: 10, const_pc: 1'b0, e_to: 1'b0, e_st: 1'b0, e_cnt: 10};
    vecs[3] = '{halt_at: 1,  const_pc: 1'b0, e_to: 1'b0, e_st: 1'b0, e_cnt: 1};
    vecs[4] = '{halt_at: 0,  const_pc: 1'b1, e_to: !STALL_EN, e_st: STALL_EN,
                e_cnt: STALL_EN ? 4 : 10};
    vecs[5] = '{halt_at: 4,  const_pc: 1'b1, e_to: 1'b0, e_st: 1'b0, e_cnt: 4};
    vecs[6] = '{halt_at: 3,  const_pc: 1'b1, e_to: 1'b0, e_st: 1'b0, e_cnt: 3};
    vecs[7] = '{halt_at: 9,  const_pc: 1'b0, e_to: 1'b0, e_st: 1'b0, e_cnt: 9};

    // Reset state
    do_reset;
    chk("rst_core_reset", bus.core_reset, 1);
    chk("rst_running", bus.running, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_stalled", bus.stalled, 0);
    chk("rst_count", bus.cycle_count, 0);

    // Hold length, with start left high through HOLD and early RUN
    bus.pc    = 32'h100;
    bus.start = 1'b1;
    tick;
    chk("hold1_core_reset", bus.core_reset, 1);
    chk("hold1_running", bus.running, 0);
    tick;
    chk("hold2_core_reset", bus.core_reset, 1);
    tick;
    chk("run_core_reset", bus.core_reset, 0);
    chk("run_running", bus.running, 1);
    run_until(5, 1'b0);
    bus.start = 1'b0;
    chk("start_in_run_done", bus.done, 1);
    chk("start_in_run_count", bus.cycle_count, 5);

    // Rerun from DONE clears stats on entering HOLD
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("rerun_done_clr", bus.done, 0);
    chk("rerun_count_clr", bus.cycle_count, 0);
    chk("rerun_core_reset", bus.core_reset, 1);
    tick;
    tick;
    chk("rerun_running", bus.running, 1);

    // Table-driven runs
    for (int i = 0; i < 8; i++) begin
      do_reset;
      start_run(vecs[i].const_pc);
      run_until(vecs[i].halt_at, vecs[i].const_pc);
      chk($sformatf("v%0d_done", i), bus.done, 1);
      chk($sformatf("v%0d_timeout", i), bus.timeout, 32'(vecs[i].e_to));
      chk($sformatf("v%0d_stalled", i), bus.stalled, 32'(vecs[i].e_st));
      chk($sformatf("v%0d_count", i), bus.cycle_count, 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_core_reset", i), bus.core_reset, 1);
      chk($sformatf("v%0d_running", i), bus.running, 0);
    end

    // Freeze in DONE after a budget timeout
    do_reset;
    start_run(1'b0);
    run_until(0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.halt = k[0];
      bus.pc   = 32'h40;
      tick;
    end
    bus.halt = 1'b0;
    chk("frz_done", bus.done, 1);
    chk("frz_timeout", bus.timeout, 1);
    chk("frz_stalled", bus.stalled, 0);
    chk("frz_count", bus.cycle_count, 10);
    chk("frz_running", bus.running, 0);

    // Reset on RUN cycle 3 overrides start and halt
    do_reset;
    start_run(1'b0);
    tick;
    tick;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.halt  = 1'b1;
    tick;
    chk("mid_core_reset", bus.core_reset, 1);
    chk("mid_running", bus.running, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_timeout", bus.timeout, 0);
    chk("mid_stalled", bus.stalled, 0);
    chk("mid_count", bus.cycle_count, 0);
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    tick;
    tick;
    chk("mid_idle_core_reset", bus.core_reset, 1);
    chk("mid_idle_running", bus.running, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2: core reset hold length after start, in cycles, >=1.
REQ-002 SHALL have parameter MAX_CYCLES, default 200: run-cycle budget before timeout, >=2.
REQ-003 SHALL have parameter STALL_LIMIT, default 16: consecutive unchanged-PC cycles that flag a stall, >=2.
REQ-004 SHALL have parameter PC_W, default 32: width of the observed PC.
REQ-005 SHALL have parameter CNT_W, default 16: cycle counter width; must hold MAX_CYCLES.
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port start  input  1  single-cycle request to begin a run.
REQ-009 SHALL have port halt  input  1  core end-of-program indication (ebreak/ecall retire).
REQ-010 SHALL have port pc  input  PC_W  core fetch PC, observed for stall detection.
REQ-011 SHALL have port core_reset  output  1  reset driven to the core under control.
REQ-012 SHALL have port running  output  1  high while in RUN.
REQ-013 SHALL have port done  output  1  sticky run-finished flag.
REQ-014 SHALL have port timeout  output  1  sticky; run ended on budget exhaustion.
REQ-015 SHALL have port stalled  output  1  sticky; run ended on PC stall.
REQ-016 SHALL have port cycle_count  output  CNT_W  RUN cycles elapsed in the current or last run.

Function
REQ-017 SHALL implement FSM states IDLE, HOLD, RUN, DONE; all outputs registered.
REQ-018 IDLE: core_reset=1, running=0; start -> HOLD.
REQ-019 Entering HOLD SHALL clear cycle_count, done, timeout, stalled and the stall counter.
REQ-020 HOLD SHALL keep core_reset=1 for exactly RST_CYCLES cycles, then go to RUN; start during HOLD is ignored.
REQ-021 RUN: core_reset=0, running=1; cycle_count increments by 1 on every RUN edge, including the terminating edge.
REQ-022 RUN with halt=1 at an edge -> DONE, done=1.
REQ-023 RUN with cycle_count==MAX_CYCLES-1 at an edge and halt=0 -> DONE, done=1, timeout=1, cycle_count=MAX_CYCLES.
REQ-024 Termination priority in the same cycle: halt > stall > timeout; exactly one cause flag (or none for halt) SHALL be set.
REQ-025 start during RUN SHALL be ignored.
REQ-026 DONE: core_reset=1, running=0, done/timeout/stalled/cycle_count frozen; start -> HOLD (rerun).
REQ-027 cycle_count SHALL never exceed MAX_CYCLES and never wrap.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE from any state, overriding start/halt in the same cycle.
REQ-029 Reset values: core_reset=1, running=0, done=0, timeout=0, stalled=0, cycle_count=0, stall counter=0, PC register=0.
REQ-030 Reset mid-RUN SHALL abandon the run with no cause flag set.

Configuration
REQ-031 Macro RUN_CTRL_STALL_DETECT_EN SHALL compile in stall detection.
REQ-032 With the macro: pc registered every cycle in HOLD and RUN; in RUN, stall counter increments when pc equals the registered pc, else clears; reaching STALL_LIMIT -> DONE, done=1, stalled=1.
REQ-033 Without the macro: no PC register or stall counter; stalled tied 0; pc input unused.

Verification (RST_CYCLES=2, MAX_CYCLES=10, STALL_LIMIT=4)
REQ-034 reset 2 cycles, start pulse -> core_reset=1 for exactly 2 cycles after start, then 0 with running=1.
REQ-035 halt pulsed on the 5th RUN cycle -> done=1, cycle_count=5, timeout=0, stalled=0, core_reset=1.
REQ-036 halt held 0, pc incrementing by 4 -> after 10 RUN cycles done=1, timeout=1, cycle_count=10; further edges leave all values unchanged.
REQ-037 halt=1 on the 10th RUN cycle -> done=1, timeout=0, cycle_count=10.
REQ-038 macro defined, pc held 0x40 -> stalled=1, done=1 after 4 matching RUN cycles; macro undefined, same stimulus -> timeout=1 at cycle_count=10.
REQ-039 reset asserted on the 3rd RUN cycle with start=1 -> next cycle IDLE, core_reset=1, all flags 0, cycle_count=0.
